// File: rtl/spi_block_slave.sv
// SPI mode-0 block slave: full-width word in on mosi, full-width word out on miso, MSB first,
// oversampled in the clk domain. Define SPI_BLOCK_SLAVE_ERR_EN to add the aborted-frame err pulse.
module spi_block_slave #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy
`ifdef SPI_BLOCK_SLAVE_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [2:0]       cs_sync, sclk_sync, mosi_sync;
  logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-2:0] rx_q;
  logic [CW-1:0]    cnt;
  logic             reload_pend;
  logic             mosi_bit;

  assign mosi_bit = mosi_sync[2];

  // Two sync flops plus one history flop per input; strobes are registered so that
  // mosi_sync[2] lines up with the registered sclk strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: cs history resets to the idle (high) level so busy reads 0 and no false cs edge is seen.
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 3'b000;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[1:0], cs};
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[1:0], mosi};
      sclk_rise <= sclk_sync[1] & ~sclk_sync[2];
      sclk_fall <= ~sclk_sync[1] & sclk_sync[2];
      cs_fall   <= ~cs_sync[1] & cs_sync[2];
      cs_rise   <= cs_sync[1] & ~cs_sync[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    miso = (state == SHIFT) ? tx_q[WIDTH-1] : 1'b0;
    busy = ~cs_sync[2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q        <= '0;
      rx_q        <= '0;
      cnt         <= '0;
      reload_pend <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        cnt         <= '0;
        reload_pend <= 1'b0;
        if (cs_fall) tx_q <= data_in;
      end else if (cs_rise) begin
        cnt         <= '0;
        reload_pend <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_q <= {rx_q[WIDTH-3:0], mosi_bit};
          if (cnt == CW'(WIDTH - 1)) begin
            data_out    <= {rx_q, mosi_bit};
            done        <= 1'b1;
            cnt         <= '0;
            tx_q        <= data_in;
            reload_pend <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The reload at a wrap stands in for the falling-edge shift of the last bit.
        if (sclk_fall) begin
          if (reload_pend) reload_pend <= 1'b0;
          else             tx_q <= {tx_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

`ifdef SPI_BLOCK_SLAVE_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= (state == SHIFT) && cs_rise && (cnt != '0);
  end
`endif

endmodule

// File: tb/tb_spi_block_slave.sv
// Directed bench for spi_block_slave: reset, single and back-to-back frames, abort,
// minimum clock ratio and sclk activity with cs high.
module tb_spi_block_slave;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cs = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         done;
  logic         busy;
`ifdef SPI_BLOCK_SLAVE_ERR_EN
  logic         err;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  spi_block_slave #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .data_in(data_in), .data_out(data_out), .done(done), .busy(busy)
`ifdef SPI_BLOCK_SLAVE_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
`ifdef SPI_BLOCK_SLAVE_ERR_EN
    if (err) err_cnt++;
`endif
  end

  task automatic chk_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Master side: nbits of word with sclk half-period h clk; miso sampled just before each rise.
  task automatic xfer(input logic [W-1:0] word, input int nbits, input int h,
                      output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[W-1-i];
      repeat (h) @(negedge clk);
      rx   = {rx[W-2:0], miso};
      sclk = 1'b1;
      repeat (h) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [W-1:0] word, input logic [W-1:0] din, input int h,
                       output logic [W-1:0] rx);
    data_in = din;
    @(negedge clk);
    cs = 1'b0;
    xfer(word, W, h, rx);
    repeat (h) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [W-1:0] rx;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_bit("reset_miso", miso, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_word("reset_data_out", data_out, '0);

    // Reset during a frame, after 40 bits.
    data_in = 128'hffffffffffffffffffffffffffffffff;
    cs = 1'b0;
    xfer(128'h0123456789abcdef0123456789abcdef, 40, 5, rx);
    reset = 1'b1;
    @(negedge clk);
    chk_bit("midreset_miso", miso, 1'b0);
    chk_bit("midreset_busy", busy, 1'b0);
    chk_bit("midreset_done", done, 1'b0);
    chk_word("midreset_data_out", data_out, '0);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    done_cnt = 0;
    frame(128'h5555aaaa0f0f3c3cdeadbeef12345678, 128'h13579bdf02468ace1122334455667788, 5, rx);
    chk_word("postreset_data_out", data_out, 128'h5555aaaa0f0f3c3cdeadbeef12345678);
    chk_word("postreset_miso_word", rx, 128'h13579bdf02468ace1122334455667788);
  endtask

  task automatic test_single;
    logic [W-1:0] rx;
    done_cnt = 0;
    frame(128'h00112233445566778899aabbccddeeff, 128'hffeeddccbbaa99887766554433221100, 5, rx);
    chk_int("single_done_count", done_cnt, 1);
    chk_word("single_data_out", data_out, 128'h00112233445566778899aabbccddeeff);
    chk_word("single_miso_word", rx, 128'hffeeddccbbaa99887766554433221100);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] rx1, rx2;
    done_cnt = 0;
    data_in = 128'hcafef00d0badc0de8badf00dfeedface;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    data_in = 128'h1;
    xfer(128'h0, W, 5, rx1);
    chk_word("b2b_data_out_first", data_out, 128'h0);
    xfer({W{1'b1}}, W, 5, rx2);
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk_int("b2b_done_count", done_cnt, 2);
    chk_word("b2b_data_out_last", data_out, {W{1'b1}});
    chk_word("b2b_miso_first", rx1, 128'hcafef00d0badc0de8badf00dfeedface);
    chk_word("b2b_miso_second", rx2, 128'h1);
  endtask

  task automatic test_abort;
    logic [W-1:0] rx;
    done_cnt = 0;
    err_cnt  = 0;
    data_in = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    @(negedge clk);
    cs = 1'b0;
    xfer(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 64, 5, rx);
    chk_bit("abort_busy_mid", busy, 1'b1);
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk_int("abort_done_count", done_cnt, 0);
    chk_word("abort_data_out_kept", data_out, {W{1'b1}});
    chk_bit("abort_busy_after", busy, 1'b0);
`ifdef SPI_BLOCK_SLAVE_ERR_EN
    chk_int("abort_err_count", err_cnt, 1);
`endif
    frame(128'h89abcdef0123456789abcdef01234567, 128'h00ff00ff00ff00ff00ff00ff00ff00ff, 5, rx);
    chk_word("abort_next_data_out", data_out, 128'h89abcdef0123456789abcdef01234567);
    chk_word("abort_next_miso_word", rx, 128'h00ff00ff00ff00ff00ff00ff00ff00ff);
`ifdef SPI_BLOCK_SLAVE_ERR_EN
    chk_int("abort_next_err_count", err_cnt, 1);
`endif
  endtask

  task automatic test_boundary;
    logic [W-1:0] rx;
    done_cnt = 0;
    frame({(W/2){2'b10}}, {(W/2){2'b10}}, 4, rx);
    chk_int("boundary_done_count", done_cnt, 1);
    chk_word("boundary_data_out", data_out, {(W/2){2'b10}});
    chk_word("boundary_miso_word", rx, {(W/2){2'b10}});
  endtask

  task automatic test_cs_high_sclk;
    logic [W-1:0] rx;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk_int("cshigh_done_count", done_cnt, 0);
    chk_word("cshigh_data_out", data_out, {(W/2){2'b10}});
    chk_bit("cshigh_miso", miso, 1'b0);
    // A following frame only lands correctly if the bit counter stayed at zero.
    frame(128'h3c3c3c3c5a5a5a5a96969696c3c3c3c3, 128'h7e7e7e7e81818181e7e7e7e718181818, 5, rx);
    chk_int("cshigh_next_done_count", done_cnt, 1);
    chk_word("cshigh_next_data_out", data_out, 128'h3c3c3c3c5a5a5a5a96969696c3c3c3c3);
    chk_word("cshigh_next_miso_word", rx, 128'h7e7e7e7e81818181e7e7e7e718181818);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_boundary();
    test_cs_high_sclk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_block_slave.md
# spi_block_slave

SPI mode-0 slave that transfers a full AES block per frame: shifts a WIDTH-bit word in on mosi while shifting a WIDTH-bit word out on miso, MSB first. It sits between the byte-level SPI master link and the AES core. The received plaintext or key is presented as one parallel word. The ciphertext returned by the core is streamed back during the same frame. All SPI inputs are oversampled in the system clock domain; no logic runs on sclk.

## Interface
- WIDTH, 128, frame length in bits; must be a multiple of 8, at least 8.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip select, active low.
- sclk  input  1  SPI clock from master; idle low (CPOL=0, CPHA=0).
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master; driven 0 when cs is high.
- data_in  input  WIDTH  word to transmit; captured at frame start and at each wrap.
- data_out  output  WIDTH  last complete received word; held between frames.
- done  output  1  one-cycle pulse when a full WIDTH-bit word has been received.
- busy  output  1  high while the synchronized cs is low.
- err  output  1  present only with SPI_BLOCK_SLAVE_ERR_EN; see Configuration.

## Operation
- Synchronization:
  - cs, sclk and mosi each pass through a 2-flop synchronizer.
  - A third flop on sclk and on cs provides edge detection.
  - mosi is delayed identically, so it stays aligned with sclk.
- States:
  - IDLE: cs high. busy=0, miso=0, bit counter=0.
  - SHIFT: entered on the detected cs falling edge.
    - tx shift register loaded with data_in; miso = data_in[WIDTH-1] from the next cycle.
    - Each detected sclk rising edge: rx shift register shifts left, synchronized mosi into bit 0; counter increments.
    - Each detected sclk falling edge: tx shifts left; miso = new MSB.
  - On the rising edge that brings the counter to WIDTH:
    - data_out takes the complete rx word (including that last bit) and done pulses for one cycle.
    - Counter wraps to 0 and tx reloads from data_in. Further sclk edges within the same cs start a new frame back-to-back.
    - The reload replaces the falling-edge shift for that bit, so miso carries the new MSB.
  - Detected cs rising edge from SHIFT: return to IDLE; the partial rx word is discarded and data_out is unchanged.
- sclk edges while synchronized cs is high are ignored.
- cs falling and an sclk edge detected in the same cycle: cs wins. The load happens and the sclk edge is ignored; the master must respect setup.
- Reset (at any time, including mid-frame) forces IDLE and clears all registers.

## Timing
- Reset values: miso=0, data_out=0, done=0, busy=0, err=0; internal shift registers and counter 0.
- Input-to-detect latency: 3 clk from a pin edge to the internal edge strobe.
- done and the data_out update occur 1 clk after the strobe for bit WIDTH, i.e. 4 clk after the pin edge.
- miso changes 4 clk after the sclk falling edge at the pin, or after the cs falling edge for the first bit.
- sclk high and low phases must each be at least 4 clk. cs low to first sclk rising edge must be at least 4 clk.
- data_in must be stable from 1 clk before the cs-fall strobe and before each wrap strobe.
- busy follows cs with 3 clk latency, both edges.

## Configuration
- SPI_BLOCK_SLAVE_ERR_EN defined:
  - err port exists.
  - err pulses high for one clk when cs deasserts with counter ≠ 0, i.e. an aborted partial frame.
  - The pulse occurs in the same cycle the state returns to IDLE.
- Undefined: no err port; partial frames are silently discarded.

## Test plan
- Reset asserted mid-frame after 40 bits → miso=0, busy=0, done=0, data_out=0 within 1 clk; the next full frame transfers correctly.
- Single frame, sclk period 10 clk:
  - master sends 128'h00112233445566778899aabbccddeeff; data_in=128'hffeeddccbbaa99887766554433221100.
  - Expect done exactly once; data_out=128'h00112233445566778899aabbccddeeff.
  - Master receives 128'hffeeddccbbaa99887766554433221100.
- Two back-to-back frames in one cs: 128'h0 then all-ones; data_in changed between frames to 128'h1 → two done pulses; data_out ends as all-ones; master receives 128'h…, then 128'h1.
- Abort: cs released after 64 bits of 128'hdeadbeef… → no done; data_out keeps its previous value; err pulses once (with ERR_EN); the next frame is correct.
- Boundary clock ratio: sclk high/low = 4 clk each, all-alternating pattern 128'haaaa…aaaa both directions → zero bit errors.
- sclk toggling 8 times with cs high → counter, data_out and miso unchanged; no done.
